tictactoe_turn_ctrl: RTL

Turn sequencer for the tic-tac-toe game. It owns the alternation between players and the move-submission handshake. It drives the position and validate strobe into the move-validation datapath, then sequences the post-move win/draw check. It sits between the player input logic (switches/buttons) and the board register/validation datapath, and declares the end of the game.

---
 rtl/ttt_pkg.sv | 29 ++
 rtl/turn_timer.sv | 28 ++
 rtl/tictactoe_turn_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer.
// Optional turn-timeout feature is controlled by the TTT_TURN_TIMEOUT_EN macro.
package ttt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MOVE,
        LOAD,
        VALIDATE,
        CHECK,
        DONE
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned POS_W     = 4;

    function automatic logic pos_legal(input logic [POS_W-1:0] pos);
        return pos < POS_W'(NUM_CELLS);
    endfunction

    function automatic logic [1:0] win_code(input logic pid);
        return pid ? WIN_P2 : WIN_P1;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Idle-turn timer: counts while enabled, pulses tc at TIMEOUT_CYCLES-1 and wraps.
// Only instantiated when TTT_TURN_TIMEOUT_EN is defined.
module turn_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned CNT_W          = 28
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tc = enable && (cnt_q == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tictactoe_turn_ctrl.sv
// Tic-tac-toe turn sequencer: player alternation, move handshake and win/draw check.
// Define TTT_TURN_TIMEOUT_EN to enable forfeiting an idle turn after TIMEOUT_CYCLES.
module tictactoe_turn_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned CNT_W          = 28
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             move_req,
    input  logic [POS_W-1:0] move_pos,
    input  logic             valid_done,
    input  logic             win_detect,
    input  logic             board_full,
    output logic             board_clr,
    output logic             validar_jugada,
    output logic [POS_W-1:0] pos_out,
    output logic             player_id,
    output logic             move_ack,
    output logic             move_rej,
    output logic             game_over,
    output logic [1:0]       winner,
    output logic             turn_timeout
);

    state_t           state_q;
    logic             board_clr_q;
    logic             validar_q;
    logic [POS_W-1:0] pos_q;
    logic             player_q;
    logic             move_ack_q;
    logic             move_rej_q;
    logic             game_over_q;
    logic [1:0]       winner_q;
    logic             timer_tc;

`ifdef TTT_TURN_TIMEOUT_EN
    logic turn_timeout_q;

    // Held clear outside WAIT_MOVE so every entry starts from zero.
    turn_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (state_q != WAIT_MOVE),
        .enable(state_q == WAIT_MOVE),
        .tc    (timer_tc)
    );

    assign turn_timeout = turn_timeout_q;
`else
    logic unused_cfg;

    assign timer_tc     = 1'b0;
    assign turn_timeout = 1'b0;
    assign unused_cfg   = ^{TIMEOUT_CYCLES, CNT_W, timer_tc};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            board_clr_q <= 1'b0;
            validar_q   <= 1'b0;
            pos_q       <= '0;
            player_q    <= 1'b0;
            move_ack_q  <= 1'b0;
            move_rej_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
`ifdef TTT_TURN_TIMEOUT_EN
            turn_timeout_q <= 1'b0;
`endif
        end else begin
            board_clr_q <= 1'b0;
            validar_q   <= 1'b0;
            move_ack_q  <= 1'b0;
            move_rej_q  <= 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
            turn_timeout_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        board_clr_q <= 1'b1;
                        player_q    <= 1'b0;
                        winner_q    <= WIN_NONE;
                        game_over_q <= 1'b0;
                        state_q     <= WAIT_MOVE;
                    end
                end
                WAIT_MOVE: begin
                    if (move_req) begin
                        if (pos_legal(move_pos)) begin
                            pos_q   <= move_pos;
                            state_q <= LOAD;
                        end else begin
                            move_rej_q <= 1'b1;
                        end
                    end
`ifdef TTT_TURN_TIMEOUT_EN
                    else if (timer_tc) begin
                        turn_timeout_q <= 1'b1;
                        player_q       <= ~player_q;
                    end
`endif
                end
                LOAD: begin
                    validar_q <= 1'b1;
                    state_q   <= VALIDATE;
                end
                VALIDATE: begin
                    if (valid_done) begin
                        move_ack_q <= 1'b1;
                        state_q    <= CHECK;
                    end else begin
                        move_rej_q <= 1'b1;
                        state_q    <= WAIT_MOVE;
                    end
                end
                CHECK: begin
                    // Win outranks a full board: the last mark can do both.
                    if (win_detect) begin
                        winner_q    <= win_code(player_q);
                        game_over_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (board_full) begin
                        winner_q    <= WIN_NONE;
                        game_over_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        player_q <= ~player_q;
                        state_q  <= WAIT_MOVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign board_clr      = board_clr_q;
    assign validar_jugada = validar_q;
    assign pos_out        = pos_q;
    assign player_id      = player_q;
    assign move_ack       = move_ack_q;
    assign move_rej       = move_rej_q;
    assign game_over      = game_over_q;
    assign winner         = winner_q;

endmodule
